// File: rtl/mlkem_pkg.sv
// ML-KEM constants and the twiddle sequencer state type.
// Shared by the twiddle generator, the Barrett reducer and twofoldunit.
package mlkem_pkg;
    localparam int Q         = 3329;
    localparam int W         = 12;
    localparam int BARRETT_K = 24;
    localparam int BARRETT_M = 5039;
    localparam int PROD_W    = 24;
    localparam int MUL_W     = 37;

    typedef enum logic [1:0] {IDLE, EMIT, MUL, RED} state_t;
endpackage

// File: rtl/barrett_reduce.sv
// Combinational Barrett reduction of a 24-bit product down to a residue in [0, Q).
// The quotient estimate can fall short by up to two, so two conditional subtractions follow.
module barrett_reduce
    import mlkem_pkg::*;
#(
    parameter int Q         = mlkem_pkg::Q,
    parameter int W         = mlkem_pkg::W,
    parameter int BARRETT_K = mlkem_pkg::BARRETT_K,
    parameter int BARRETT_M = mlkem_pkg::BARRETT_M
) (
    input  logic [PROD_W-1:0] prod,
    output logic [W-1:0]      r
);

    function automatic logic [PROD_W-1:0] csub(input logic [PROD_W-1:0] x);
        return (x >= PROD_W'(Q)) ? x - PROD_W'(Q) : x;
    endfunction

    logic [MUL_W-1:0]  prod_m;
    logic [MUL_W-1:0]  t;
    logic [PROD_W-1:0] tq;
    logic [PROD_W-1:0] r0;
    logic [PROD_W-1:0] r2;

    always_comb begin
        prod_m = MUL_W'(prod) * MUL_W'(BARRETT_M);
        t      = prod_m >> BARRETT_K;
        tq     = PROD_W'(t * MUL_W'(Q));
        r0     = prod - tq;
        r2     = csub(csub(r0));
        r      = W'(r2);
    end

endmodule

// File: rtl/twiddle_seq_gen.sv
// Emits ZETA^k mod Q for k = 0..COUNT-1 over a valid/ready handshake,
// one modular multiply (MUL) and one Barrett reduction (RED) per twiddle.
module twiddle_seq_gen
    import mlkem_pkg::*;
#(
    parameter int Q         = mlkem_pkg::Q,
    parameter int ZETA      = 17,
    parameter int COUNT     = 128,
    parameter int W         = mlkem_pkg::W,
    parameter int BARRETT_K = mlkem_pkg::BARRETT_K,
    parameter int BARRETT_M = mlkem_pkg::BARRETT_M
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic [W-1:0] w_out,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [6:0]   w_idx,
    output logic         done
);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                last_hs;
    logic [W-1:0]        acc_p0;
    logic [PROD_W-1:0]   prod_p1;
    logic [W-1:0]        red_p2;
    logic [6:0]          idx;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A start that lands on the done cycle is dropped so a run cannot chain back-to-back.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_hs   = 1'b0;
        w_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    accept    = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                w_valid = 1'b1;
                if (w_ready) begin
                    if (idx == 7'(COUNT - 1)) begin
                        last_hs   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = MUL;
                    end
                end
            end
            MUL:     state_nxt = RED;
            RED:     state_nxt = EMIT;
            default: state_nxt = IDLE;
        endcase
    end

    assign w_out = w_valid ? acc_p0 : '0;
    assign w_idx = idx;

    // Stage p0: running power acc and its exponent
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_p0 <= W'(1);
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= last_hs;
            if (accept) begin
                acc_p0 <= W'(1);
                idx    <= '0;
                busy   <= 1'b1;
            end
            if (last_hs) busy <= 1'b0;
            if (state == RED) begin
                acc_p0 <= red_p2;
                idx    <= idx + 7'd1;
            end
        end
    end

    // Stage p1: registered product acc * ZETA
    always_ff @(posedge clock) begin
        if (state == MUL) prod_p1 <= PROD_W'(acc_p0) * PROD_W'(ZETA);
    end

    // Stage p2: reduction of the product back into [0, Q)
    barrett_reduce #(
        .Q         (Q),
        .W         (W),
        .BARRETT_K (BARRETT_K),
        .BARRETT_M (BARRETT_M)
    ) u_barrett (
        .prod (prod_p1),
        .r    (red_p2)
    );

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Bench for twiddle_seq_gen: a per-cycle behavioural model of the handshake schedule and
// the power table ZETA^k mod Q, plus directed checks pinned to hand-computed values.
module tb_twiddle_seq_gen;
    localparam int Q     = 3329;
    localparam int ZETA  = 17;
    localparam int COUNT = 128;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic [11:0] w_out;
    logic        w_valid;
    logic        w_ready;
    logic [6:0]  w_idx;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    int pow_tab [0:COUNT-1];

    bit m_live  = 1'b0;
    bit m_valid = 1'b0;
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;
    bit m_rst   = 1'b0;
    int m_k     = 0;
    int m_wait  = 0;

    twiddle_seq_gen dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .w_out   (w_out),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_idx   (w_idx),
        .done    (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Check the DUT against the model for the current cycle, then advance the model
    // by one cycle using the inputs that the coming edge will sample.
    task automatic model_step();
        bit nd;
        if (m_live) begin
            chk("m_valid", int'(w_valid), int'(m_valid));
            chk("m_busy", int'(busy), int'(m_busy));
            chk("m_done", int'(done), int'(m_done));
            chk("m_range", int'(w_out < 12'(Q)), 1);
            if (m_valid) begin
                chk("m_w_out", int'(w_out), pow_tab[m_k]);
                chk("m_w_idx", int'(w_idx), m_k);
            end
            if (m_rst) begin
                chk("m_rst_w_out", int'(w_out), 0);
                chk("m_rst_w_idx", int'(w_idx), 0);
            end
        end
        if (reset) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_rst   = 1'b1;
            m_k     = 0;
            m_wait  = 0;
        end else if (m_live) begin
            nd    = 1'b0;
            m_rst = 1'b0;
            if (!m_busy && start && !m_done) begin
                m_busy  = 1'b1;
                m_valid = 1'b1;
                m_k     = 0;
            end else if (m_valid && w_ready) begin
                m_valid = 1'b0;
                if (m_k == COUNT - 1) begin
                    m_busy = 1'b0;
                    nd     = 1'b1;
                end else begin
                    m_k++;
                    m_wait = 2;
                end
            end else if (m_busy && !m_valid) begin
                if (m_wait == 1) m_valid = 1'b1;
                else             m_wait--;
            end
            m_done = nd;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            model_step();
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int n;
        pow_tab[0] = 1;
        for (int k = 1; k < COUNT; k++) pow_tab[k] = (pow_tab[k-1] * ZETA) % Q;

        reset   = 1'b1;
        start   = 1'b0;
        w_ready = 1'b1;
        tick(3);
        chk("rst_valid", int'(w_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_w_out", int'(w_out), 0);
        chk("rst_w_idx", int'(w_idx), 0);
        reset = 1'b0;
        tick(2);

        // First run, consumer always ready: cycle numbers relative to the start edge.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("c1_valid", int'(w_valid), 1);
        chk("c1_w_out", int'(w_out), 1);
        chk("c1_w_idx", int'(w_idx), 0);
        chk("c1_busy", int'(busy), 1);
        tick(1);
        chk("c2_valid", int'(w_valid), 0);
        tick(2);
        chk("c4_w_out", int'(w_out), 17);
        chk("c4_w_idx", int'(w_idx), 1);
        tick(3);
        chk("c7_w_out", int'(w_out), 289);
        tick(3);
        chk("c10_w_out", int'(w_out), 1584);
        chk("c10_w_idx", int'(w_idx), 3);
        tick(372);
        chk("c382_valid", int'(w_valid), 1);
        chk("c382_w_idx", int'(w_idx), 127);
        chk("c382_w_out", int'(w_out), 2154);
        tick(1);
        chk("c383_done", int'(done), 1);
        chk("c383_busy", int'(busy), 0);
        chk("c383_valid", int'(w_valid), 0);

        // Start coinciding with done is dropped; the next cycle's start is taken.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("ign_done_valid", int'(w_valid), 0);
        chk("ign_done_busy", int'(busy), 0);
        chk("ign_done_done", int'(done), 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("restart_w_out", int'(w_out), 1);
        chk("restart_w_idx", int'(w_idx), 0);
        chk("restart_valid", int'(w_valid), 1);

        // Backpressure while 289 is presented.
        tick(5);
        w_ready = 1'b0;
        tick(1);
        chk("bp_w_out", int'(w_out), 289);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_hold_w_out", int'(w_out), 289);
            chk("bp_hold_w_idx", int'(w_idx), 2);
            chk("bp_hold_valid", int'(w_valid), 1);
        end
        w_ready = 1'b1;
        tick(3);
        chk("bp_resume_w_out", int'(w_out), 1584);
        chk("bp_resume_w_idx", int'(w_idx), 3);

        // Start pulse mid-run at w_idx 5 changes nothing.
        tick(6);
        chk("mid_w_idx", int'(w_idx), 5);
        chk("mid_w_out", int'(w_out), 1703);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("mid_valid", int'(w_valid), 0);
        chk("mid_busy", int'(busy), 1);
        tick(2);
        chk("mid_next_w_idx", int'(w_idx), 6);
        chk("mid_next_w_out", int'(w_out), 2319);

        // Reset during MUL after w_idx 40 was handed off.
        tick(103);
        chk("mul40_valid", int'(w_valid), 0);
        chk("mul40_w_idx", int'(w_idx), 40);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mrst_valid", int'(w_valid), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_w_out", int'(w_out), 0);
        chk("mrst_w_idx", int'(w_idx), 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("post_rst_w_out", int'(w_out), 1);
        chk("post_rst_w_idx", int'(w_idx), 0);

        // Full run to completion, bounded.
        n = 0;
        while (!done && n < 500) begin
            tick(1);
            n++;
        end
        chk("final_done_cycle", n + 1, 383);
        tick(2);
        chk("final_idle_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
